// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx: zero-wait-state memory-mapped 8N1 serial transmitter.
// A 4-byte register window sits at BASE_ADDR: TXDATA, STATUS, CTRL and a reserved byte.
// Bytes written to TXDATA are queued in a small FIFO and shifted out LSB first on tx.
// The read-data port is named dout because "do" is a reserved word in SystemVerilog.
// Optional feature macro: MMIO_UART_TX_PARITY_EN. When it is defined, an even-parity
// bit is sent between the data bits and the stop bit.

module mmio_uart_tx #(
    parameter logic [15:0] BASE_ADDR    = 16'hFF00,
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] addr,
    input  logic [7:0]  di,
    input  logic        we,
    output logic [7:0]  dout,
    output logic        sel,
    output logic        tx
);

    localparam int unsigned PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    localparam logic [1:0] OFF_TXDATA = 2'd0;
    localparam logic [1:0] OFF_STATUS = 2'd1;
    localparam logic [1:0] OFF_CTRL   = 2'd2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef MMIO_UART_TX_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_e;

    // Register state
    state_e              state_q,    state_d;
    logic [BAUD_W-1:0]   baud_q,     baud_d;
    logic [2:0]          bit_idx_q,  bit_idx_d;
    logic [7:0]          shift_q,    shift_d;
    logic                tx_q,       tx_d;
    logic [PTR_W-1:0]    wr_ptr_q,   wr_ptr_d;
    logic [PTR_W-1:0]    rd_ptr_q,   rd_ptr_d;
    logic [CNT_W-1:0]    count_q,    count_d;
    logic                overflow_q, overflow_d;
    logic                enable_q,   enable_d;
    logic [7:0]          mem_q [FIFO_DEPTH];
    logic [7:0]          mem_d [FIFO_DEPTH];
`ifdef MMIO_UART_TX_PARITY_EN
    logic                parity_q,   parity_d;
`endif

    // Decode and handshake helpers
    logic [16:0] addr_ext_c;
    logic [1:0]  reg_off_c;
    logic        wr_txdata_c;
    logic        wr_ctrl_c;
    logic        fifo_full_c;
    logic        fifo_empty_c;
    logic        pop_c;
    logic        push_c;
    logic        ovf_evt_c;
    logic        baud_last_c;
    logic [7:0]  head_c;
    logic [4:0]  count5_c;
    logic [3:0]  count_sat_c;
    logic [7:0]  status_c;

    // Address window decode; 17-bit compare so a window near the top of memory does not wrap.
    always_comb begin
        addr_ext_c  = {1'b0, addr};
        sel         = (addr_ext_c >= {1'b0, BASE_ADDR}) &&
                      (addr_ext_c <= ({1'b0, BASE_ADDR} + 17'd3));
        reg_off_c   = 2'(addr - BASE_ADDR);
        wr_txdata_c = we && sel && (reg_off_c == OFF_TXDATA);
        wr_ctrl_c   = we && sel && (reg_off_c == OFF_CTRL);
    end

    // FIFO status, push/pop arbitration and baud terminal count
    always_comb begin
        fifo_full_c  = (count_q == CNT_W'(FIFO_DEPTH));
        fifo_empty_c = (count_q == '0);
        pop_c        = (state_q == S_IDLE) && enable_q && !fifo_empty_c;
        push_c       = wr_txdata_c && (!fifo_full_c || pop_c);
        ovf_evt_c    = wr_txdata_c && !push_c;
        baud_last_c  = (baud_q == BAUD_W'(CLKS_PER_BIT - 1));
        head_c       = mem_q[rd_ptr_q];
    end

    // FIFO pointers, occupancy, sticky overflow and enable
    always_comb begin
        mem_d      = mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        enable_d   = enable_q;

        if (push_c) begin
            mem_d[wr_ptr_q] = di;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop_c) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push_c, pop_c})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        // An overflow in the same cycle as a clear request leaves the flag set.
        if (ovf_evt_c) begin
            overflow_d = 1'b1;
        end else if (wr_ctrl_c && di[1]) begin
            overflow_d = 1'b0;
        end
        if (wr_ctrl_c) begin
            enable_d = di[0];
        end
    end

    // TX framing FSM: next state, baud counter, shifter and line value
    always_comb begin
        state_d   = state_q;
        baud_d    = baud_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        tx_d      = tx_q;
`ifdef MMIO_UART_TX_PARITY_EN
        parity_d  = parity_q;
`endif

        case (state_q)
            S_IDLE: begin
                baud_d = '0;
                tx_d   = 1'b1;
                if (pop_c) begin
                    state_d   = S_START;
                    shift_d   = head_c;
                    bit_idx_d = 3'd0;
                    tx_d      = 1'b0;
`ifdef MMIO_UART_TX_PARITY_EN
                    parity_d  = ^head_c;
`endif
                end
            end
            S_START: begin
                baud_d = baud_q + BAUD_W'(1);
                if (baud_last_c) begin
                    baud_d  = '0;
                    state_d = S_DATA;
                    tx_d    = shift_q[0];
                end
            end
            S_DATA: begin
                baud_d = baud_q + BAUD_W'(1);
                if (baud_last_c) begin
                    baud_d = '0;
                    if (bit_idx_q == 3'd7) begin
`ifdef MMIO_UART_TX_PARITY_EN
                        state_d = S_PARITY;
                        tx_d    = parity_q;
`else
                        state_d = S_STOP;
                        tx_d    = 1'b1;
`endif
                    end else begin
                        shift_d   = shift_q >> 1;
                        tx_d      = shift_q[1];
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end
            end
`ifdef MMIO_UART_TX_PARITY_EN
            S_PARITY: begin
                baud_d = baud_q + BAUD_W'(1);
                if (baud_last_c) begin
                    baud_d  = '0;
                    state_d = S_STOP;
                    tx_d    = 1'b1;
                end
            end
`endif
            S_STOP: begin
                baud_d = baud_q + BAUD_W'(1);
                tx_d   = 1'b1;
                if (baud_last_c) begin
                    baud_d  = '0;
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                baud_d  = '0;
                tx_d    = 1'b1;
            end
        endcase
    end

    // Control and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            baud_q     <= '0;
            bit_idx_q  <= '0;
            shift_q    <= '0;
            tx_q       <= 1'b1;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            enable_q   <= 1'b1;
`ifdef MMIO_UART_TX_PARITY_EN
            parity_q   <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            baud_q     <= baud_d;
            bit_idx_q  <= bit_idx_d;
            shift_q    <= shift_d;
            tx_q       <= tx_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            enable_q   <= enable_d;
`ifdef MMIO_UART_TX_PARITY_EN
            parity_q   <= parity_d;
`endif
        end
    end

    // FIFO storage; contents are meaningless while count is zero, so no reset
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    // Combinational read mux; count field saturates at 15 for a 16-deep FIFO
    always_comb begin
        count5_c    = 5'(count_q);
        count_sat_c = (count5_c > 5'd15) ? 4'hF : count5_c[3:0];
        status_c    = {count_sat_c, overflow_q, (state_q != S_IDLE), fifo_empty_c, fifo_full_c};
        dout        = 8'h00;
        if (sel) begin
            case (reg_off_c)
                OFF_STATUS: dout = status_c;
                OFF_CTRL:   dout = {7'b0, enable_q};
                default:    dout = 8'h00;
            endcase
        end
    end

    assign tx = tx_q;

endmodule

// File: tb/tb_mmio_uart_tx.sv
// tb_mmio_uart_tx: directed bench for mmio_uart_tx with CLKS_PER_BIT = 4, FIFO_DEPTH = 4.
// Build with MMIO_UART_TX_PARITY_EN defined to exercise the parity frames as well.

module tb_mmio_uart_tx;

    localparam logic [15:0] BASE = 16'hFF00;
    localparam int unsigned CPB  = 4;
`ifdef MMIO_UART_TX_PARITY_EN
    localparam int unsigned NBITS = 11;
`else
    localparam int unsigned NBITS = 10;
`endif

    logic        clk;
    logic        rst;
    logic [15:0] addr;
    logic [7:0]  di;
    logic        we;
    logic [7:0]  dout;
    logic        sel;
    logic        tx;

    int n_checks;
    int n_fails;

    mmio_uart_tx #(
        .BASE_ADDR    (BASE),
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (4)
    ) u_dut (
        .clk  (clk),
        .rst  (rst),
        .addr (addr),
        .di   (di),
        .we   (we),
        .dout (dout),
        .sel  (sel),
        .tx   (tx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %02h expected %02h", tag, got, exp);
        end
    endtask

    // One-cycle write; the write lands on the posedge between the two negedges.
    task automatic bus_write(input logic [15:0] a, input logic [7:0] d);
        @(negedge clk);
        addr = a;
        di   = d;
        we   = 1'b1;
        @(negedge clk);
        we   = 1'b0;
        di   = 8'h00;
    endtask

    task automatic bus_read(input logic [15:0] a, output logic [7:0] d, output logic s);
        @(negedge clk);
        addr = a;
        #1;
        d = dout;
        s = sel;
    endtask

    // Expects the next negedge to be the first one after the pop edge.
    task automatic expect_frame(input logic [7:0] b);
        logic bits [NBITS];
        bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) bits[i+1] = b[i];
`ifdef MMIO_UART_TX_PARITY_EN
        bits[9] = ^b;
`endif
        bits[NBITS-1] = 1'b1;
        for (int k = 0; k < int'(NBITS); k++) begin
            for (int c = 0; c < int'(CPB); c++) begin
                @(negedge clk);
                addr = BASE + 16'd1;
                #1;
                check_eq($sformatf("frame %02h bit %0d cyc %0d tx", b, k, c), 8'(tx), 8'(bits[k]));
                check_eq($sformatf("frame %02h bit %0d cyc %0d busy", b, k, c), 8'(dout[2]), 8'h01);
            end
        end
    endtask

    logic [7:0] rd;
    logic       rs;
    int         lows;
    logic [7:0] seq [4];

    initial begin
        n_checks = 0;
        n_fails  = 0;
        rst  = 1'b1;
        addr = 16'h0000;
        di   = 8'h00;
        we   = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Reset state and address decode
        bus_read(BASE + 16'd1, rd, rs);
        check_eq("status after reset", rd, 8'h02);
        check_eq("sel status", 8'(rs), 8'h01);
        check_eq("tx idle after reset", 8'(tx), 8'h01);
        bus_read(BASE + 16'd2, rd, rs);
        check_eq("ctrl after reset", rd, 8'h01);
        bus_read(16'h1234, rd, rs);
        check_eq("do outside window", rd, 8'h00);
        check_eq("sel outside window", 8'(rs), 8'h00);
        bus_read(BASE, rd, rs);
        check_eq("txdata reads zero", rd, 8'h00);
        bus_read(BASE + 16'd3, rd, rs);
        check_eq("reserved reads zero", rd, 8'h00);
        check_eq("sel at base+3", 8'(rs), 8'h01);
        bus_read(BASE + 16'd4, rd, rs);
        check_eq("sel at base+4", 8'(rs), 8'h00);
        bus_read(BASE - 16'd1, rd, rs);
        check_eq("sel at base-1", 8'(rs), 8'h00);

        // Writes outside the window and to the reserved byte are ignored
        bus_write(16'hFE02, 8'h00);
        bus_write(BASE + 16'd3, 8'hFF);
        bus_read(BASE + 16'd2, rd, rs);
        check_eq("ctrl after stray writes", rd, 8'h01);
        bus_read(BASE + 16'd1, rd, rs);
        check_eq("status after stray writes", rd, 8'h02);

        // Single frame 0xA5
        bus_write(BASE, 8'hA5);
        expect_frame(8'hA5);
        bus_read(BASE + 16'd1, rd, rs);
        check_eq("status after A5 frame", rd, 8'h02);
        check_eq("tx idle after A5 frame", 8'(tx), 8'h01);

        // Fill with transmitter disabled, overflow and its clear
        bus_write(BASE + 16'd2, 8'h00);
        bus_write(BASE, 8'h11);
        bus_write(BASE, 8'h22);
        bus_write(BASE, 8'h33);
        bus_write(BASE, 8'h44);
        bus_read(BASE + 16'd1, rd, rs);
        check_eq("status full no ovf", rd, 8'h41);
        bus_write(BASE, 8'h55);
        bus_read(BASE + 16'd1, rd, rs);
        check_eq("status full ovf", rd, 8'h49);
        check_eq("tx idle while disabled", 8'(tx), 8'h01);
        bus_write(BASE + 16'd2, 8'h02);
        bus_read(BASE + 16'd1, rd, rs);
        check_eq("status after ovf clear", rd, 8'h41);
        bus_read(BASE + 16'd2, rd, rs);
        check_eq("ctrl clear bit reads 0", rd, 8'h00);
        bus_write(BASE, 8'h66);
        bus_read(BASE + 16'd1, rd, rs);
        check_eq("status ovf again", rd, 8'h49);
        bus_write(BASE + 16'd2, 8'h00);
        bus_read(BASE + 16'd1, rd, rs);
        check_eq("ovf sticky without clear", rd, 8'h49);

        // Enable: four queued frames back to back, one idle clock between
        seq[0] = 8'h11; seq[1] = 8'h22; seq[2] = 8'h33; seq[3] = 8'h44;
        bus_write(BASE + 16'd2, 8'h01);
        for (int f = 0; f < 4; f++) begin
            expect_frame(seq[f]);
            bus_read(BASE + 16'd1, rd, rs);
            check_eq($sformatf("gap %0d busy", f), 8'(rd[2]), 8'h00);
            check_eq($sformatf("gap %0d tx", f), 8'(tx), 8'h01);
        end
        check_eq("status after drain", rd, 8'h0A);
        bus_write(BASE + 16'd2, 8'h03);
        bus_read(BASE + 16'd1, rd, rs);
        check_eq("status after final clear", rd, 8'h02);
        lows = 0;
        repeat (12 * CPB) begin
            @(negedge clk);
            if (tx !== 1'b1) lows++;
        end
        check_eq("no extra frame sent", 8'(lows), 8'h00);

        // Reset in the middle of DATA bit 3 of 0x0F, with 0x5A queued
        bus_write(BASE, 8'h0F);
        bus_write(BASE, 8'h5A);
        repeat (16) @(negedge clk);
        #1;
        check_eq("0F data bit 3 before reset", 8'(tx), 8'h01);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_eq("tx after mid-frame reset", 8'(tx), 8'h01);
        addr = BASE + 16'd1;
        #1;
        check_eq("status after mid-frame reset", dout, 8'h02);
        lows = 0;
        repeat (12 * CPB) begin
            @(negedge clk);
            if (tx !== 1'b1) lows++;
        end
        check_eq("tx quiet after reset", 8'(lows), 8'h00);
        bus_read(BASE + 16'd2, rd, rs);
        check_eq("ctrl after mid-frame reset", rd, 8'h01);

`ifdef MMIO_UART_TX_PARITY_EN
        // Parity frames: 0x07 has odd weight (parity 1), 0x03 even (parity 0)
        bus_write(BASE, 8'h07);
        expect_frame(8'h07);
        bus_read(BASE + 16'd1, rd, rs);
        check_eq("status after 07 parity frame", rd, 8'h02);
        bus_write(BASE, 8'h03);
        expect_frame(8'h03);
        bus_read(BASE + 16'd1, rd, rs);
        check_eq("status after 03 parity frame", rd, 8'h02);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
